// File: rtl/glb_tile_cfg_queue_pkg.sv
// Shared configuration for the GLB tile config queue: default sizes, bus widths,
// the header record and the register-index decode used by the top and its channels.
package glb_tile_cfg_queue_pkg;

    localparam int GLB_NUM_CH      = 2;
    localparam int GLB_QUEUE_DEPTH = 4;
    localparam int CFG_ADDR_W      = 12;
    localparam int CFG_DATA_W      = 32;
    localparam int TILE_SEL_W      = 5;
    localparam int ADDR_W          = 22;
    localparam int WORDS_W         = 21;
    localparam int CTRL_W          = 8;

    localparam int CTRL_IDX         = 0;
    localparam int STATUS_BASE      = 1;
    localparam int HDR_STRIDE       = 3;
    localparam int STATUS_WLOCK_BIT = 30;
    localparam int STATUS_UFLOW_BIT = 31;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  start_addr;
        logic [WORDS_W-1:0] num_words;
    } hdr_t;

    typedef enum logic [1:0] {
        FIELD_VALIDATE   = 2'd0,
        FIELD_START_ADDR = 2'd1,
        FIELD_NUM_WORDS  = 2'd2
    } hdr_field_e;

    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_HDR    = 2'd3
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [7:0] ch;
        logic [7:0] entry;
        hdr_field_e field;
    } reg_dec_t;

    function automatic int hdr_base(input int num_ch);
        return STATUS_BASE + num_ch;
    endfunction

    function automatic int num_regs(input int num_ch, input int qdepth);
        return 1 + num_ch + HDR_STRIDE * num_ch * qdepth;
    endfunction

    // Headers are laid out channel-major, entry-minor, three registers per entry.
    function automatic reg_dec_t decode_idx(input int idx, input int num_ch, input int qdepth);
        reg_dec_t d;
        int       off;
        d.kind  = REG_NONE;
        d.ch    = '0;
        d.entry = '0;
        d.field = FIELD_VALIDATE;
        off     = idx - hdr_base(num_ch);
        if (idx == CTRL_IDX) begin
            d.kind = REG_CTRL;
        end else if (idx >= STATUS_BASE && idx < hdr_base(num_ch)) begin
            d.kind = REG_STATUS;
            d.ch   = 8'(idx - STATUS_BASE);
        end else if (idx >= hdr_base(num_ch) && idx < num_regs(num_ch, qdepth)) begin
            d.kind  = REG_HDR;
            d.ch    = 8'(off / (HDR_STRIDE * qdepth));
            d.entry = 8'((off / HDR_STRIDE) % qdepth);
            d.field = hdr_field_e'(2'(off % HDR_STRIDE));
        end
        return d;
    endfunction

endpackage

// File: rtl/glb_tile_cfg_queue_if.sv
// Daisy-chained config bus segment between neighbouring GLB tiles.
// The master drives requests and receives read data; the slave does the reverse.
interface glb_tile_cfg_queue_if
    import glb_tile_cfg_queue_pkg::*;
#(
    parameter int AW = CFG_ADDR_W,
    parameter int DW = CFG_DATA_W
) ();

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_data_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_data_valid
    );

endinterface

// File: rtl/glb_tile_cfg_queue_hdr_queue.sv
// One DMA channel: a ring of header entries, the hardware head pointer,
// consume handling and the sticky write_locked / underflow status bits.
module glb_cfg_hdr_queue
    import glb_tile_cfg_queue_pkg::*;
#(
    parameter  int QUEUE_DEPTH = GLB_QUEUE_DEPTH,
    localparam int QPTR_W      = $clog2(QUEUE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hdr_wr_i,
    input  logic [QPTR_W-1:0]     wr_entry_i,
    input  hdr_field_e            wr_field_i,
    input  logic                  status_wr_i,
    input  logic [CFG_DATA_W-1:0] wr_data_i,
    input  logic                  consume_i,
    input  logic [QPTR_W-1:0]     rd_entry_i,
    input  hdr_field_e            rd_field_i,
    output logic [CFG_DATA_W-1:0] hdr_rd_data_o,
    output logic [CFG_DATA_W-1:0] status_o,
    output hdr_t                  head_o
);

    hdr_t              entries_q [QUEUE_DEPTH];
    hdr_t              entries_d [QUEUE_DEPTH];
    logic [QPTR_W-1:0] head_q, head_d;
    logic              wlock_q, wlock_d;
    logic              uflow_q, uflow_d;
    logic [QPTR_W:0]   count;
    logic              unused_wr_data;

    assign unused_wr_data = ^wr_data_i;

    // Order matters: W1C first so a same-cycle set wins, then SW writes, then
    // consume last so it overrides a VALIDATE aimed at the head entry.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        wlock_d   = wlock_q;
        uflow_d   = uflow_q;
        if (status_wr_i) begin
            if (wr_data_i[STATUS_WLOCK_BIT]) wlock_d = 1'b0;
            if (wr_data_i[STATUS_UFLOW_BIT]) uflow_d = 1'b0;
        end
        if (hdr_wr_i) begin
            case (wr_field_i)
                FIELD_VALIDATE: entries_d[wr_entry_i].valid = wr_data_i[0];
                FIELD_START_ADDR: begin
                    if (entries_q[wr_entry_i].valid) wlock_d = 1'b1;
                    else entries_d[wr_entry_i].start_addr = wr_data_i[ADDR_W-1:0];
                end
                FIELD_NUM_WORDS: begin
                    if (entries_q[wr_entry_i].valid) wlock_d = 1'b1;
                    else entries_d[wr_entry_i].num_words = wr_data_i[WORDS_W-1:0];
                end
                default: ;
            endcase
        end
        if (consume_i) begin
            entries_d[head_q].valid = 1'b0;
            if (entries_q[head_q].valid) head_d = head_q + QPTR_W'(1);
            else uflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            wlock_q <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            wlock_q   <= wlock_d;
            uflow_q   <= uflow_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            count = count + {{QPTR_W{1'b0}}, entries_q[i].valid};
        end
    end

    always_comb begin
        status_o                   = '0;
        status_o[QPTR_W-1:0]       = head_q;
        status_o[2*QPTR_W:QPTR_W]  = count;
        status_o[STATUS_WLOCK_BIT] = wlock_q;
        status_o[STATUS_UFLOW_BIT] = uflow_q;
    end

    always_comb begin
        hdr_rd_data_o = '0;
        case (rd_field_i)
            FIELD_VALIDATE:   hdr_rd_data_o = CFG_DATA_W'(entries_q[rd_entry_i].valid);
            FIELD_START_ADDR: hdr_rd_data_o = CFG_DATA_W'(entries_q[rd_entry_i].start_addr);
            FIELD_NUM_WORDS:  hdr_rd_data_o = CFG_DATA_W'(entries_q[rd_entry_i].num_words);
            default: ;
        endcase
    end

    assign head_o = entries_q[head_q];

endmodule

// File: rtl/glb_tile_cfg_queue.sv
// Per-tile config register bank with NUM_CH DMA header queues, sitting on the
// west-to-east config chain and forwarding every request east one cycle later.
module glb_tile_cfg_queue
    import glb_tile_cfg_queue_pkg::*;
#(
    parameter int NUM_CH      = GLB_NUM_CH,
    parameter int QUEUE_DEPTH = GLB_QUEUE_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [TILE_SEL_W-1:0]     glb_tile_id,
    glb_tile_cfg_queue_if.slave       cfg_wst,
    glb_tile_cfg_queue_if.master      cfg_est,
    input  logic [NUM_CH-1:0]         dma_consume_pulse,
    output logic [CTRL_W-1:0]         cfg_ctrl,
    output logic [NUM_CH-1:0]         dma_head_valid,
    output logic [NUM_CH*ADDR_W-1:0]  dma_head_start_addr,
    output logic [NUM_CH*WORDS_W-1:0] dma_head_num_words
);

    localparam int QPTR_W    = $clog2(QUEUE_DEPTH);
    localparam int NUM_REGS  = num_regs(NUM_CH, QUEUE_DEPTH);
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    if (CFG_ADDR_W < TILE_SEL_W + REG_IDX_W + 2) begin : g_addr_too_narrow
        $error("glb_tile_cfg_queue: CFG_ADDR_W too narrow for tile id and register index");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("glb_tile_cfg_queue: QUEUE_DEPTH must be a power of two >= 2");
    end

    logic                  wr_hit, rd_hit;
    logic [REG_IDX_W-1:0]  wr_idx, rd_idx;
    reg_dec_t              wr_dec, rd_dec;
    logic [CFG_DATA_W-1:0] status_w  [NUM_CH];
    logic [CFG_DATA_W-1:0] hdr_rd_w  [NUM_CH];
    hdr_t                  head_w    [NUM_CH];
    logic [CFG_DATA_W-1:0] local_rd_data;

    logic [CTRL_W-1:0]     ctrl_q;
    logic [CFG_DATA_W-1:0] wst_rd_data_q;
    logic                  wst_rd_valid_q;
    logic                  est_wr_en_q, est_rd_en_q;
    logic [CFG_ADDR_W-1:0] est_wr_addr_q, est_rd_addr_q;
    logic [CFG_DATA_W-1:0] est_wr_data_q;
    logic                  unused_bits;

    assign wr_hit = cfg_wst.wr_en && (cfg_wst.wr_addr[CFG_ADDR_W-1 -: TILE_SEL_W] == glb_tile_id);
    assign rd_hit = cfg_wst.rd_en && (cfg_wst.rd_addr[CFG_ADDR_W-1 -: TILE_SEL_W] == glb_tile_id);
    assign wr_idx = cfg_wst.wr_addr[REG_IDX_W+1:2];
    assign rd_idx = cfg_wst.rd_addr[REG_IDX_W+1:2];
    assign wr_dec = decode_idx(int'(wr_idx), NUM_CH, QUEUE_DEPTH);
    assign rd_dec = decode_idx(int'(rd_idx), NUM_CH, QUEUE_DEPTH);

    assign unused_bits = ^{cfg_wst.wr_addr, cfg_wst.rd_addr, wr_dec, rd_dec};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        glb_cfg_hdr_queue #(
            .QUEUE_DEPTH(QUEUE_DEPTH)
        ) u_queue (
            .clk           (clk),
            .reset         (reset),
            .hdr_wr_i      (wr_hit && wr_dec.kind == REG_HDR && wr_dec.ch == 8'(c)),
            .wr_entry_i    (wr_dec.entry[QPTR_W-1:0]),
            .wr_field_i    (wr_dec.field),
            .status_wr_i   (wr_hit && wr_dec.kind == REG_STATUS && wr_dec.ch == 8'(c)),
            .wr_data_i     (cfg_wst.wr_data),
            .consume_i     (dma_consume_pulse[c]),
            .rd_entry_i    (rd_dec.entry[QPTR_W-1:0]),
            .rd_field_i    (rd_dec.field),
            .hdr_rd_data_o (hdr_rd_w[c]),
            .status_o      (status_w[c]),
            .head_o        (head_w[c])
        );

        assign dma_head_valid[c]                        = head_w[c].valid;
        assign dma_head_start_addr[c*ADDR_W +: ADDR_W]  = head_w[c].start_addr;
        assign dma_head_num_words[c*WORDS_W +: WORDS_W] = head_w[c].num_words;
    end

    // Out-of-range indices fall through to zero but still answer with valid.
    always_comb begin
        local_rd_data = '0;
        case (rd_dec.kind)
            REG_CTRL: local_rd_data = CFG_DATA_W'(ctrl_q);
            REG_STATUS: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (rd_dec.ch == 8'(c)) local_rd_data = status_w[c];
                end
            end
            REG_HDR: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (rd_dec.ch == 8'(c)) local_rd_data = hdr_rd_w[c];
                end
            end
            default: ;
        endcase
    end

    // A local hit owns the west return path; tile ids are unique so no east
    // response can legitimately collide with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q         <= '0;
            wst_rd_data_q  <= '0;
            wst_rd_valid_q <= 1'b0;
            est_wr_en_q    <= 1'b0;
            est_wr_addr_q  <= '0;
            est_wr_data_q  <= '0;
            est_rd_en_q    <= 1'b0;
            est_rd_addr_q  <= '0;
        end else begin
            if (wr_hit && wr_dec.kind == REG_CTRL) ctrl_q <= cfg_wst.wr_data[CTRL_W-1:0];
            if (rd_hit) begin
                wst_rd_data_q  <= local_rd_data;
                wst_rd_valid_q <= 1'b1;
            end else begin
                wst_rd_data_q  <= cfg_est.rd_data;
                wst_rd_valid_q <= cfg_est.rd_data_valid;
            end
            est_wr_en_q   <= cfg_wst.wr_en;
            est_wr_addr_q <= cfg_wst.wr_addr;
            est_wr_data_q <= cfg_wst.wr_data;
            est_rd_en_q   <= cfg_wst.rd_en;
            est_rd_addr_q <= cfg_wst.rd_addr;
        end
    end

    assign cfg_ctrl              = ctrl_q;
    assign cfg_wst.rd_data       = wst_rd_data_q;
    assign cfg_wst.rd_data_valid = wst_rd_valid_q;
    assign cfg_est.wr_en         = est_wr_en_q;
    assign cfg_est.wr_addr       = est_wr_addr_q;
    assign cfg_est.wr_data       = est_wr_data_q;
    assign cfg_est.rd_en         = est_rd_en_q;
    assign cfg_est.rd_addr       = est_rd_addr_q;

endmodule

// File: tb/tb_glb_tile_cfg_queue.sv
// Self-checking bench for glb_tile_cfg_queue: read responses go through a
// scoreboard queue, head outputs and forwarded signals are checked inline.
module tb_glb_tile_cfg_queue;
    import glb_tile_cfg_queue_pkg::*;

    localparam logic [TILE_SEL_W-1:0] MY_TILE    = 5'd3;
    localparam logic [TILE_SEL_W-1:0] OTHER_TILE = 5'd7;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [TILE_SEL_W-1:0]         glb_tile_id;
    logic [GLB_NUM_CH-1:0]         dma_consume_pulse;
    logic [CTRL_W-1:0]             cfg_ctrl;
    logic [GLB_NUM_CH-1:0]         dma_head_valid;
    logic [GLB_NUM_CH*ADDR_W-1:0]  dma_head_start_addr;
    logic [GLB_NUM_CH*WORDS_W-1:0] dma_head_num_words;

    glb_tile_cfg_queue_if wst ();
    glb_tile_cfg_queue_if est ();

    glb_tile_cfg_queue dut (
        .clk                 (clk),
        .reset               (reset),
        .glb_tile_id         (glb_tile_id),
        .cfg_wst             (wst),
        .cfg_est             (est),
        .dma_consume_pulse   (dma_consume_pulse),
        .cfg_ctrl            (cfg_ctrl),
        .dma_head_valid      (dma_head_valid),
        .dma_head_start_addr (dma_head_start_addr),
        .dma_head_num_words  (dma_head_num_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CFG_DATA_W-1:0] data;
        int unsigned           cyc;
    } rd_exp_t;

    rd_exp_t     sb [$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc++;

    // Every west read response must match the oldest outstanding expectation
    // and arrive exactly one cycle after its request.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (reset === 1'b0 && wst.rd_data_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL rd_unexpected: got response %h, required none", wst.rd_data);
            end else begin
                e = sb.pop_front();
                if (wst.rd_data !== e.data) begin
                    fails++;
                    $display("[TB] FAIL rd_data: got %h, required %h", wst.rd_data, e.data);
                end
                tests++;
                if (cyc !== e.cyc + 1) begin
                    fails++;
                    $display("[TB] FAIL rd_latency: got %0d cycles, required 1", cyc - e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [CFG_ADDR_W-1:0] mk_addr(input logic [TILE_SEL_W-1:0] tile, input int idx);
        logic [4:0] i5;
        i5 = 5'(idx);
        return {tile, i5, 2'b00};
    endfunction

    function automatic int hdr_idx(input int c, input int q, input int k);
        return 1 + GLB_NUM_CH + 3 * (c * GLB_QUEUE_DEPTH + q) + k;
    endfunction

    task automatic cfg_write(input logic [TILE_SEL_W-1:0] tile, input int idx, input logic [31:0] data);
        @(negedge clk);
        wst.wr_en   = 1'b1;
        wst.wr_addr = mk_addr(tile, idx);
        wst.wr_data = data;
        @(negedge clk);
        wst.wr_en   = 1'b0;
        wst.wr_data = '0;
    endtask

    task automatic cfg_read(input logic [TILE_SEL_W-1:0] tile, input int idx, input logic [31:0] exp);
        @(negedge clk);
        wst.rd_en   = 1'b1;
        wst.rd_addr = mk_addr(tile, idx);
        sb.push_back('{data: exp, cyc: cyc});
        @(negedge clk);
        wst.rd_en   = 1'b0;
    endtask

    task automatic pulse_consume(input logic [GLB_NUM_CH-1:0] mask);
        @(negedge clk);
        dma_consume_pulse = mask;
        @(negedge clk);
        dma_consume_pulse = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({dma_head_valid, cfg_ctrl, dma_head_start_addr, dma_head_num_words} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got valid=%b ctrl=%h start=%h words=%h, required all 0",
                     dma_head_valid, cfg_ctrl, dma_head_start_addr, dma_head_num_words);
        end
        tests++;
        if ({est.wr_en, est.wr_addr, est.wr_data, est.rd_en, est.rd_addr} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_east: got wr_en=%b rd_en=%b wr_addr=%h, required 0",
                     est.wr_en, est.rd_en, est.wr_addr);
        end
        tests++;
        if ({wst.rd_data_valid, wst.rd_data} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_west: got valid=%b data=%h, required 0", wst.rd_data_valid, wst.rd_data);
        end
        @(negedge clk);
        reset = 1'b0;
        cfg_read(MY_TILE, 1, 32'h0);
    endtask

    task automatic test_single_header;
        cfg_write(MY_TILE, hdr_idx(0, 0, 1), 32'h0000_1234);
        cfg_write(MY_TILE, hdr_idx(0, 0, 2), 32'd64);
        tests++;
        if (dma_head_valid !== 2'b00) begin
            fails++;
            $display("[TB] FAIL head_before_validate: got %b, required 00", dma_head_valid);
        end
        cfg_write(MY_TILE, hdr_idx(0, 0, 0), 32'h1);
        tests++;
        if (dma_head_valid !== 2'b01 || dma_head_start_addr[ADDR_W-1:0] !== 22'h1234 ||
            dma_head_num_words[WORDS_W-1:0] !== 21'd64) begin
            fails++;
            $display("[TB] FAIL head_ch0: got valid=%b start=%h words=%0d, required 01/1234/64",
                     dma_head_valid, dma_head_start_addr[ADDR_W-1:0], dma_head_num_words[WORDS_W-1:0]);
        end
        cfg_read(MY_TILE, 1, 32'h0000_0004);
        cfg_read(MY_TILE, hdr_idx(0, 0, 1), 32'h0000_1234);

        cfg_write(MY_TILE, 0, 32'h0000_01A5);
        tests++;
        if (cfg_ctrl !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL ctrl_write: got %h, required a5", cfg_ctrl);
        end
        tests++;
        if (est.wr_en !== 1'b1 || est.wr_data !== 32'h0000_01A5 || est.wr_addr !== mk_addr(MY_TILE, 0)) begin
            fails++;
            $display("[TB] FAIL east_fwd_hit: got en=%b addr=%h data=%h, required 1/%h/000001a5",
                     est.wr_en, est.wr_addr, est.wr_data, mk_addr(MY_TILE, 0));
        end
        cfg_read(MY_TILE, 0, 32'h0000_00A5);

        cfg_write(MY_TILE, hdr_idx(1, 0, 1), 32'hFFFF_FFFF);
        cfg_write(MY_TILE, hdr_idx(1, 0, 2), 32'hFFFF_FFFF);
        cfg_write(MY_TILE, hdr_idx(1, 0, 0), 32'h1);
        tests++;
        if (dma_head_valid !== 2'b11 || dma_head_start_addr[ADDR_W +: ADDR_W] !== 22'h3F_FFFF ||
            dma_head_num_words[WORDS_W +: WORDS_W] !== 21'h1F_FFFF) begin
            fails++;
            $display("[TB] FAIL head_ch1_trunc: got valid=%b start=%h words=%h, required 11/3fffff/1fffff",
                     dma_head_valid, dma_head_start_addr[ADDR_W +: ADDR_W], dma_head_num_words[WORDS_W +: WORDS_W]);
        end
        cfg_read(MY_TILE, hdr_idx(1, 0, 1), 32'h003F_FFFF);
        cfg_read(MY_TILE, 2, 32'h0000_0004);
    endtask

    task automatic test_consume_wrap;
        logic [ADDR_W-1:0] m_start [GLB_QUEUE_DEPTH];
        int                head_m, cnt_m;
        logic              uf_m;
        m_start[0] = 22'h1234;
        for (int q = 1; q < GLB_QUEUE_DEPTH; q++) begin
            m_start[q] = 22'(32'h1000 + q);
            cfg_write(MY_TILE, hdr_idx(0, q, 1), 32'h1000 + q);
            cfg_write(MY_TILE, hdr_idx(0, q, 0), 32'h1);
        end
        head_m = 0;
        cnt_m  = GLB_QUEUE_DEPTH;
        uf_m   = 1'b0;
        cfg_read(MY_TILE, 1, 32'h0000_0010);
        for (int p = 0; p < 5; p++) begin
            pulse_consume(2'b01);
            if (cnt_m > 0) begin
                head_m = (head_m + 1) % GLB_QUEUE_DEPTH;
                cnt_m--;
            end else begin
                uf_m = 1'b1;
            end
            tests++;
            if (dma_head_valid[0] !== (cnt_m > 0)) begin
                fails++;
                $display("[TB] FAIL consume_head_valid[%0d]: got %b, required %b", p, dma_head_valid[0], cnt_m > 0);
            end
            if (cnt_m > 0) begin
                tests++;
                if (dma_head_start_addr[ADDR_W-1:0] !== m_start[head_m]) begin
                    fails++;
                    $display("[TB] FAIL consume_head_start[%0d]: got %h, required %h",
                             p, dma_head_start_addr[ADDR_W-1:0], m_start[head_m]);
                end
            end
            cfg_read(MY_TILE, 1, {uf_m, 26'd0, 3'(cnt_m), 2'(head_m)});
        end
        cfg_write(MY_TILE, 1, 32'h8000_0000);
        cfg_read(MY_TILE, 1, 32'h0000_0000);
    endtask

    task automatic test_write_lock;
        cfg_write(MY_TILE, hdr_idx(0, 0, 0), 32'h1);
        cfg_write(MY_TILE, hdr_idx(0, 0, 1), 32'h0000_FFFF);
        tests++;
        if (dma_head_start_addr[ADDR_W-1:0] !== 22'h1234) begin
            fails++;
            $display("[TB] FAIL locked_start: got %h, required 1234", dma_head_start_addr[ADDR_W-1:0]);
        end
        cfg_read(MY_TILE, hdr_idx(0, 0, 1), 32'h0000_1234);
        cfg_read(MY_TILE, 1, 32'h4000_0004);

        @(negedge clk);
        wst.wr_en         = 1'b1;
        wst.wr_addr       = mk_addr(MY_TILE, hdr_idx(0, 0, 0));
        wst.wr_data       = 32'h1;
        dma_consume_pulse = 2'b01;
        @(negedge clk);
        wst.wr_en         = 1'b0;
        dma_consume_pulse = '0;
        tests++;
        if (dma_head_valid[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL consume_beats_validate: got head_valid %b, required 0", dma_head_valid[0]);
        end
        cfg_read(MY_TILE, 1, 32'h4000_0001);

        @(negedge clk);
        wst.wr_en         = 1'b1;
        wst.wr_addr       = mk_addr(MY_TILE, 1);
        wst.wr_data       = 32'hC000_0000;
        dma_consume_pulse = 2'b01;
        @(negedge clk);
        wst.wr_en         = 1'b0;
        dma_consume_pulse = '0;
        cfg_read(MY_TILE, 1, 32'h8000_0001);
        cfg_write(MY_TILE, 1, 32'h8000_0000);
        cfg_read(MY_TILE, 1, 32'h0000_0001);
    endtask

    task automatic test_passthrough;
        @(negedge clk);
        wst.wr_en         = 1'b1;
        wst.wr_addr       = mk_addr(OTHER_TILE, 0);
        wst.wr_data       = 32'h0000_0055;
        wst.rd_en         = 1'b1;
        wst.rd_addr       = mk_addr(OTHER_TILE, 1);
        est.rd_data       = 32'h0000_CAFE;
        est.rd_data_valid = 1'b1;
        sb.push_back('{data: 32'h0000_CAFE, cyc: cyc});
        @(negedge clk);
        wst.wr_en         = 1'b0;
        wst.rd_en         = 1'b0;
        est.rd_data       = '0;
        est.rd_data_valid = 1'b0;
        tests++;
        if (est.wr_en !== 1'b1 || est.wr_addr !== mk_addr(OTHER_TILE, 0) || est.wr_data !== 32'h0000_0055) begin
            fails++;
            $display("[TB] FAIL east_fwd_wr: got en=%b addr=%h data=%h, required 1/%h/00000055",
                     est.wr_en, est.wr_addr, est.wr_data, mk_addr(OTHER_TILE, 0));
        end
        tests++;
        if (est.rd_en !== 1'b1 || est.rd_addr !== mk_addr(OTHER_TILE, 1)) begin
            fails++;
            $display("[TB] FAIL east_fwd_rd: got en=%b addr=%h, required 1/%h",
                     est.rd_en, est.rd_addr, mk_addr(OTHER_TILE, 1));
        end
        tests++;
        if (cfg_ctrl !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL miss_ctrl: got %h, required a5", cfg_ctrl);
        end
        @(negedge clk);
        tests++;
        if (est.wr_en !== 1'b0 || est.rd_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL east_fwd_single: got wr_en=%b rd_en=%b, required 0/0", est.wr_en, est.rd_en);
        end
        cfg_write(OTHER_TILE, hdr_idx(0, 1, 0), 32'h1);
        tests++;
        if (dma_head_valid[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL miss_validate: got head_valid %b, required 0", dma_head_valid[0]);
        end
        cfg_read(MY_TILE, 1, 32'h0000_0001);
    endtask

    task automatic test_out_of_range_and_reset;
        cfg_read(MY_TILE, 27, 32'h0);
        cfg_read(MY_TILE, 31, 32'h0);
        cfg_write(MY_TILE, 27, 32'hFFFF_FFFF);
        cfg_read(MY_TILE, 0, 32'h0000_00A5);
        cfg_read(MY_TILE, 1, 32'h0000_0001);

        cfg_write(MY_TILE, hdr_idx(0, 1, 0), 32'h1);
        cfg_write(MY_TILE, hdr_idx(0, 1, 1), 32'h0000_0ABC);
        tests++;
        if (dma_head_valid[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pre_reset_head: got %b, required 1", dma_head_valid[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if ({dma_head_valid, cfg_ctrl, dma_head_start_addr, dma_head_num_words} !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset: got valid=%b ctrl=%h start=%h, required all 0",
                     dma_head_valid, cfg_ctrl, dma_head_start_addr);
        end
        tests++;
        if (est.wr_en !== 1'b0 || wst.rd_data_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset_bus: got est_wr_en=%b wst_valid=%b, required 0/0",
                     est.wr_en, wst.rd_data_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        cfg_read(MY_TILE, 1, 32'h0);
        cfg_read(MY_TILE, 2, 32'h0);
        cfg_read(MY_TILE, 0, 32'h0);
    endtask

    initial begin
        reset             = 1'b1;
        glb_tile_id       = MY_TILE;
        dma_consume_pulse = '0;
        wst.wr_en         = 1'b0;
        wst.wr_addr       = '0;
        wst.wr_data       = '0;
        wst.rd_en         = 1'b0;
        wst.rd_addr       = '0;
        est.rd_data       = '0;
        est.rd_data_valid = 1'b0;

        test_reset();
        test_single_header();
        test_consume_wrap();
        test_write_lock();
        test_passthrough();
        test_out_of_range_and_reset();

        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL rd_pending: got %0d outstanding reads, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
